timepulse_gen: RTL

- Parametrised successor to the fixed 12-pulse timer.
- Generates the memory-cycle timing chain: one-hot clock phases within each time pulse, one-hot time pulses T01..TN within each memory cycle, and a free-running scaler.
- Adds a GOJAM restart sequence, a cycle-boundary stop for MSTP/standby, and single-memory-cycle stepping.
- Drives all downstream sequence-generator and control timing.

---
 rtl/timepulse_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/timepulse_gen.sv
// ---------------------------------------------------------------------------
// timepulse_gen
//
// Memory-cycle timing chain. A one-hot phase ring (PHS) advances on every
// clock while running; each full turn of the phase ring advances a one-hot
// time-pulse ring (T). One full turn of the time-pulse ring is one memory
// cycle, and MCT_END marks its last phase. The block also runs the GOJAM
// restart sequence, stops cleanly at cycle boundaries for monitor stop
// (MSTP) or standby (SBY), and single-steps one memory cycle per STEP edge.
// A free-running scaler (FS) ticks once every SCALER_DIV clocks.
//
// Parameters:
//   NPULSE     time pulses per memory cycle (2..32)
//   NPHASE     clock phases per time pulse (2..8)
//   GOJ_CLKS   clocks GOJAM is held after reset release / GOJ drop (>=1)
//   SCALER_W   scaler counter width
//   SCALER_DIV clocks per scaler increment (>=1)
//
// Ports:
//   CLOCK    system clock, all state changes on its rising edge
//   RESET_   synchronous active-low reset
//   GOJ      restart request, level-sampled, highest priority after reset
//   MSTP     monitor stop, halts at the end of the current memory cycle
//   STEP     single-step request, its rising edge starts one cycle
//   SBY      standby request, halts at cycle end, STEP is then ignored
//   PHS      one-hot phase, zero when not running
//   T        one-hot time pulse, zero when not running
//   MCT_END  last phase of last time pulse
//   STOP     halted because of MSTP
//   STBY     halted because of SBY
//   GOJAM    restart in progress
//   GOJAM_   complement of GOJAM
//   FS       scaler count
//   FS_STB   one-clock strobe on each scaler increment
// ---------------------------------------------------------------------------
module timepulse_gen #(
   parameter int NPULSE     = 12,
   parameter int NPHASE     = 4,
   parameter int GOJ_CLKS   = 8,
   parameter int SCALER_W   = 8,
   parameter int SCALER_DIV = 4
) (
   input  logic                CLOCK,
   input  logic                RESET_,
   input  logic                GOJ,
   input  logic                MSTP,
   input  logic                STEP,
   input  logic                SBY,
   output logic [NPHASE-1:0]   PHS,
   output logic [NPULSE-1:0]   T,
   output logic                MCT_END,
   output logic                STOP,
   output logic                STBY,
   output logic                GOJAM,
   output logic                GOJAM_,
   output logic [SCALER_W-1:0] FS,
   output logic                FS_STB
);

   localparam int JAM_W = (GOJ_CLKS > 1) ? $clog2(GOJ_CLKS) : 1;
   localparam int DIV_W = (SCALER_DIV > 1) ? $clog2(SCALER_DIV) : 1;

   localparam logic [JAM_W-1:0]  JAM_LAST  = JAM_W'(GOJ_CLKS - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCALER_DIV - 1);
   localparam logic [NPHASE-1:0] PHS_FIRST = NPHASE'(1);
   localparam logic [NPULSE-1:0] T_FIRST   = NPULSE'(1);

   typedef enum logic [1:0] {
      JAM,
      RUN,
      STEP1,
      HALT
   } state_t;

   state_t            state;
   logic [JAM_W-1:0]  jam_cnt;
   logic              step_q;
   logic              step_rise;
   logic [DIV_W-1:0]  div_cnt;

   // A STEP level held high must only produce one cycle, so only the
   // 0->1 transition between two consecutive samples counts as a request.
   assign step_rise = STEP & ~step_q;

   assign GOJAM_ = ~GOJAM;

   // Previous STEP sample for the edge detector above.
   always_ff @(posedge CLOCK) begin
      if (!RESET_) begin
         step_q <= 1'b0;
      end else begin
         step_q <= STEP;
      end
   end

   // Main sequencer. Reset and GOJ both drop straight into JAM with the
   // hold counter cleared, so the GOJAM hold is always counted from the
   // first edge on which the restart cause has gone away. While running,
   // PHS rotates every clock and T rotates when PHS leaves its last bit;
   // MCT_END is predicted one clock early so it lines up exactly with
   // T[NPULSE-1] & PHS[NPHASE-1]. Stop decisions are taken only on the
   // edge that leaves an MCT_END clock, so a cycle is never cut short.
   always_ff @(posedge CLOCK) begin
      if (!RESET_) begin
         state   <= JAM;
         jam_cnt <= '0;
         PHS     <= '0;
         T       <= '0;
         MCT_END <= 1'b0;
         STOP    <= 1'b0;
         STBY    <= 1'b0;
         GOJAM   <= 1'b1;
      end else if (GOJ) begin
         state   <= JAM;
         jam_cnt <= '0;
         PHS     <= '0;
         T       <= '0;
         MCT_END <= 1'b0;
         STOP    <= 1'b0;
         STBY    <= 1'b0;
         GOJAM   <= 1'b1;
      end else begin
         case (state)
            JAM: begin
               if (jam_cnt == JAM_LAST) begin
                  state <= RUN;
                  T     <= T_FIRST;
                  PHS   <= PHS_FIRST;
                  GOJAM <= 1'b0;
               end else begin
                  jam_cnt <= jam_cnt + 1'b1;
               end
            end

            RUN, STEP1: begin
               if (MCT_END) begin
                  MCT_END <= 1'b0;
                  if (SBY) begin
                     state <= HALT;
                     STBY  <= 1'b1;
                     T     <= '0;
                     PHS   <= '0;
                  end else if (MSTP) begin
                     state <= HALT;
                     STOP  <= 1'b1;
                     T     <= '0;
                     PHS   <= '0;
                  end else begin
                     state <= RUN;
                     T     <= T_FIRST;
                     PHS   <= PHS_FIRST;
                  end
               end else begin
                  PHS <= {PHS[NPHASE-2:0], PHS[NPHASE-1]};
                  if (PHS[NPHASE-1]) begin
                     T <= {T[NPULSE-2:0], T[NPULSE-1]};
                  end
                  MCT_END <= T[NPULSE-1] & PHS[NPHASE-2];
               end
            end

            HALT: begin
               if (!SBY && !MSTP) begin
                  state <= RUN;
                  T     <= T_FIRST;
                  PHS   <= PHS_FIRST;
                  STOP  <= 1'b0;
                  STBY  <= 1'b0;
               end else if (STOP && !SBY && step_rise) begin
                  state <= STEP1;
                  T     <= T_FIRST;
                  PHS   <= PHS_FIRST;
                  STOP  <= 1'b0;
               end
            end

            default: begin
               state <= JAM;
            end
         endcase
      end
   end

   // Free-running scaler. It keeps counting through JAM and HALT and is
   // only held by reset; FS simply rolls over at its width.
   always_ff @(posedge CLOCK) begin
      if (!RESET_) begin
         div_cnt <= '0;
         FS      <= '0;
         FS_STB  <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         FS      <= FS + 1'b1;
         FS_STB  <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         FS_STB  <= 1'b0;
      end
   end

endmodule
